// File: rtl/servant_arb_pkg.sv
// Shared types and constants for the servant two-master Wishbone arbiter.
// State encodings double as the one-hot grant vector.
package servant_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } arb_state_e;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

  localparam logic [31:0] TIMEOUT_RDT = 32'hFFFF_FFFF;

endpackage

// File: rtl/servant_arb_rr.sv
// Two-input pick: round-robin (pointer favours the master not granted last)
// or fixed priority with master 0 winning ties. o_win is one-hot, 00 = none.
module servant_arb_rr
  import servant_arb_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_req,
  input  logic       i_adv,
  input  logic       i_adv_id,
  input  logic       i_rr_mode,
  output logic [1:0] o_win
);

  // ptr_q = 1 means master 1 has priority on the next tie
  logic ptr_q;
  logic ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (i_adv) ptr_d = ~i_adv_id;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) ptr_q <= 1'b0;
    else          ptr_q <= ptr_d;
  end

  always_comb begin
    o_win = GRANT_NONE;
    case (i_req)
      2'b01:   o_win = GRANT_M0;
      2'b10:   o_win = GRANT_M1;
      2'b11:   o_win = (i_rr_mode && ptr_q) ? GRANT_M1 : GRANT_M0;
      default: o_win = GRANT_NONE;
    endcase
  end

endmodule

// File: rtl/servant_arbiter.sv
// Two-master, one-slave Wishbone arbiter for the servant data bus.
// Optional watchdog enabled by defining SERVANT_ARB_TIMEOUT_EN.
module servant_arbiter
  import servant_arb_pkg::*;
#(
  parameter bit ROUND_ROBIN = 1'b1,
  parameter int TIMEOUT_W   = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_wb_m0_adr,
  input  logic [31:0] i_wb_m0_dat,
  input  logic [3:0]  i_wb_m0_sel,
  input  logic        i_wb_m0_we,
  input  logic        i_wb_m0_cyc,
  output logic [31:0] o_wb_m0_rdt,
  output logic        o_wb_m0_ack,
  input  logic [31:0] i_wb_m1_adr,
  input  logic [31:0] i_wb_m1_dat,
  input  logic [3:0]  i_wb_m1_sel,
  input  logic        i_wb_m1_we,
  input  logic        i_wb_m1_cyc,
  output logic [31:0] o_wb_m1_rdt,
  output logic        o_wb_m1_ack,
  output logic [31:0] o_wb_s_adr,
  output logic [31:0] o_wb_s_dat,
  output logic [3:0]  o_wb_s_sel,
  output logic        o_wb_s_we,
  output logic        o_wb_s_cyc,
  input  logic [31:0] i_wb_s_rdt,
  input  logic        i_wb_s_ack,
  output logic [1:0]  o_grant,
  output logic        o_err
);

  arb_state_e state_q;
  arb_state_e state_d;

  logic       gnt0;
  logic       gnt1;
  logic       owned;
  logic       own_cyc;
  logic       tmo_fire;
  logic       done;
  logic [1:0] arb_req;
  logic [1:0] win;

  assign gnt0    = (state_q == GNT0);
  assign gnt1    = (state_q == GNT1);
  assign owned   = gnt0 | gnt1;
  assign own_cyc = (gnt0 & i_wb_m0_cyc) | (gnt1 & i_wb_m1_cyc);
  assign done    = (owned & i_wb_s_ack) | tmo_fire;

  // After a completed beat in RR mode only the other master may be chained.
  always_comb begin
    arb_req = {i_wb_m1_cyc, i_wb_m0_cyc};
    if (ROUND_ROBIN) begin
      if (gnt0) arb_req = {i_wb_m1_cyc, 1'b0};
      if (gnt1) arb_req = {1'b0, i_wb_m0_cyc};
    end
  end

  servant_arb_rr u_rr (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_req     (arb_req),
    .i_adv     (done),
    .i_adv_id  (gnt1),
    .i_rr_mode (ROUND_ROBIN),
    .o_win     (win)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       state_d = arb_state_e'(win);
      GNT0, GNT1: begin
        if (done)          state_d = arb_state_e'(win);
        else if (!own_cyc) state_d = IDLE;
      end
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

`ifdef SERVANT_ARB_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] CNT_FIRE = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  logic [TIMEOUT_W-1:0] cnt_q;
  logic [TIMEOUT_W-1:0] cnt_d;
  logic                 err_q;
  logic                 err_d;

  // Fires in the cycle the counter would reach all-ones: the 2**W-1'th wait.
  assign tmo_fire = own_cyc & ~i_wb_s_ack & (cnt_q == CNT_FIRE);

  always_comb begin
    cnt_d = '0;
    if (own_cyc && !i_wb_s_ack && !tmo_fire) cnt_d = cnt_q + 1'b1;
    err_d = err_q | tmo_fire;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign o_err = err_q;
`else
  logic unused_timeout_w;
  assign unused_timeout_w = TIMEOUT_W[0];
  assign tmo_fire         = 1'b0;
  assign o_err            = 1'b0;
`endif

  assign o_wb_s_adr = gnt1 ? i_wb_m1_adr : i_wb_m0_adr;
  assign o_wb_s_dat = gnt1 ? i_wb_m1_dat : i_wb_m0_dat;
  assign o_wb_s_sel = gnt1 ? i_wb_m1_sel : i_wb_m0_sel;
  assign o_wb_s_we  = gnt1 ? i_wb_m1_we  : i_wb_m0_we;
  // Reset drops the slave cycle and swallows any ack in the same cycle.
  assign o_wb_s_cyc = i_rst_n & own_cyc;

  assign o_wb_m0_ack = i_rst_n & gnt0 & (i_wb_s_ack | tmo_fire);
  assign o_wb_m1_ack = i_rst_n & gnt1 & (i_wb_s_ack | tmo_fire);
  assign o_wb_m0_rdt = (gnt0 & tmo_fire) ? TIMEOUT_RDT : i_wb_s_rdt;
  assign o_wb_m1_rdt = (gnt1 & tmo_fire) ? TIMEOUT_RDT : i_wb_s_rdt;

  assign o_grant = state_q;

endmodule

// File: tb/tb_servant_arbiter.sv
// Directed bench for servant_arbiter: instance 0 round-robin, instance 1 fixed priority.
// Each vector is one clock cycle; outputs are compared at the falling edge.
module tb_servant_arbiter;

  localparam logic [31:0] M0_ADR = 32'h0000_0100;
  localparam logic [31:0] M1_ADR = 32'h0000_0200;
  localparam logic [31:0] M0_DAT = 32'h1111_1111;
  localparam logic [31:0] M1_DAT = 32'h2222_2222;
  localparam logic [3:0]  M0_SEL = 4'h3;
  localparam logic [3:0]  M1_SEL = 4'hC;

  logic clk;
  logic m0_adr_unused;

  logic [31:0] m0_adr, m1_adr, m0_dat, m1_dat;
  logic [3:0]  m0_sel, m1_sel;
  logic        m0_we, m1_we;

  logic        rst_n  [2];
  logic        m0_cyc [2];
  logic        m1_cyc [2];
  logic        s_ack  [2];
  logic [31:0] s_rdt  [2];
  logic [31:0] m0_rdt [2];
  logic [31:0] m1_rdt [2];
  logic        m0_ack [2];
  logic        m1_ack [2];
  logic [31:0] s_adr  [2];
  logic [31:0] s_dat  [2];
  logic [3:0]  s_sel  [2];
  logic        s_we   [2];
  logic        s_cyc  [2];
  logic [1:0]  grant  [2];
  logic        err    [2];

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    int          inst;
    logic        rst_n;
    logic        c0;
    logic        c1;
    logic        ack;
    logic [31:0] rdt;
    logic [1:0]  e_grant;
    logic        e_a0;
    logic        e_a1;
    logic        e_scyc;
    logic        e_err;
    logic [31:0] e_rdt0;
  } vec_t;

  vec_t vecs[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    servant_arbiter #(
      .ROUND_ROBIN (g == 0),
      .TIMEOUT_W   (4)
    ) u_dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n[g]),
      .i_wb_m0_adr (m0_adr),
      .i_wb_m0_dat (m0_dat),
      .i_wb_m0_sel (m0_sel),
      .i_wb_m0_we  (m0_we),
      .i_wb_m0_cyc (m0_cyc[g]),
      .o_wb_m0_rdt (m0_rdt[g]),
      .o_wb_m0_ack (m0_ack[g]),
      .i_wb_m1_adr (m1_adr),
      .i_wb_m1_dat (m1_dat),
      .i_wb_m1_sel (m1_sel),
      .i_wb_m1_we  (m1_we),
      .i_wb_m1_cyc (m1_cyc[g]),
      .o_wb_m1_rdt (m1_rdt[g]),
      .o_wb_m1_ack (m1_ack[g]),
      .o_wb_s_adr  (s_adr[g]),
      .o_wb_s_dat  (s_dat[g]),
      .o_wb_s_sel  (s_sel[g]),
      .o_wb_s_we   (s_we[g]),
      .o_wb_s_cyc  (s_cyc[g]),
      .i_wb_s_rdt  (s_rdt[g]),
      .i_wb_s_ack  (s_ack[g]),
      .o_grant     (grant[g]),
      .o_err       (err[g])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic add(input string n, input int inst, input logic r, input logic c0,
                     input logic c1, input logic ack, input logic [31:0] rdt,
                     input logic [1:0] g, input logic a0, input logic a1,
                     input logic sc, input logic er, input logic [31:0] er0);
    vec_t v;
    v.name = n;  v.inst = inst; v.rst_n = r; v.c0 = c0; v.c1 = c1; v.ack = ack;
    v.rdt = rdt; v.e_grant = g; v.e_a0 = a0; v.e_a1 = a1; v.e_scyc = sc;
    v.e_err = er; v.e_rdt0 = er0;
    vecs.push_back(v);
  endtask

  // Inputs are applied just after a rising edge; outputs compared at the falling edge.
  task automatic run_row(input vec_t v);
    int i;
    logic m1_owner;
    i = v.inst;
    rst_n[i]  = v.rst_n;
    m0_cyc[i] = v.c0;
    m1_cyc[i] = v.c1;
    s_ack[i]  = v.ack;
    s_rdt[i]  = v.rdt;
    m1_owner  = (v.e_grant == 2'b10);
    @(negedge clk);
    check({v.name, ".grant"}, 32'(grant[i]), 32'(v.e_grant));
    check({v.name, ".m0_ack"}, 32'(m0_ack[i]), 32'(v.e_a0));
    check({v.name, ".m1_ack"}, 32'(m1_ack[i]), 32'(v.e_a1));
    check({v.name, ".s_cyc"}, 32'(s_cyc[i]), 32'(v.e_scyc));
    check({v.name, ".s_adr"}, s_adr[i], m1_owner ? M1_ADR : M0_ADR);
    check({v.name, ".s_dat"}, s_dat[i], m1_owner ? M1_DAT : M0_DAT);
    check({v.name, ".s_sel"}, 32'(s_sel[i]), 32'(m1_owner ? M1_SEL : M0_SEL));
    check({v.name, ".s_we"}, 32'(s_we[i]), 32'(m1_owner));
    check({v.name, ".m0_rdt"}, m0_rdt[i], v.e_rdt0);
    check({v.name, ".m1_rdt"}, m1_rdt[i], v.rdt);
    check({v.name, ".err"}, 32'(err[i]), 32'(v.e_err));
    @(posedge clk);
    #1;
  endtask

  initial begin
    m0_adr = M0_ADR; m1_adr = M1_ADR;
    m0_dat = M0_DAT; m1_dat = M1_DAT;
    m0_sel = M0_SEL; m1_sel = M1_SEL;
    m0_we  = 1'b0;   m1_we  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b0; m0_cyc[i] = 1'b0; m1_cyc[i] = 1'b0;
      s_ack[i] = 1'b0; s_rdt[i] = 32'h0;
    end
    repeat (2) @(posedge clk);
    #1;

    //  name           inst rst c0 c1 ack rdt            grant a0 a1 scyc err rdt0
    add("rst_idle",    0, 1, 0, 0, 0, 32'h0,          2'b00, 0, 0, 0, 0, 32'h0);
    add("rd0_req",     0, 1, 1, 0, 0, 32'h0,          2'b00, 0, 0, 0, 0, 32'h0);
    add("rd0_gnt",     0, 1, 1, 0, 0, 32'h5555_5555,  2'b01, 0, 0, 1, 0, 32'h5555_5555);
    add("rd0_ack",     0, 1, 1, 0, 1, 32'hDEAD_BEEF,  2'b01, 1, 0, 1, 0, 32'hDEAD_BEEF);
    add("rd0_idle",    0, 1, 0, 0, 0, 32'h0,          2'b00, 0, 0, 0, 0, 32'h0);
    add("ab1_req",     0, 1, 0, 1, 0, 32'h0,          2'b00, 0, 0, 0, 0, 32'h0);
    add("ab1_gnt",     0, 1, 0, 1, 0, 32'h0,          2'b10, 0, 0, 1, 0, 32'h0);
    add("ab1_drop",    0, 1, 0, 0, 0, 32'h0,          2'b10, 0, 0, 0, 0, 32'h0);
    add("ab1_idle",    0, 1, 0, 0, 0, 32'h0,          2'b00, 0, 0, 0, 0, 32'h0);
    add("tie_req",     0, 1, 1, 1, 0, 32'h0,          2'b00, 0, 0, 0, 0, 32'h0);
    add("tie_m1",      0, 1, 1, 1, 1, 32'hA1A1_A1A1,  2'b10, 0, 1, 1, 0, 32'hA1A1_A1A1);
    add("tie_m0",      0, 1, 1, 0, 1, 32'hB0B0_B0B0,  2'b01, 1, 0, 1, 0, 32'hB0B0_B0B0);
    add("spur_ack",    0, 1, 0, 0, 1, 32'hC0C0_C0C0,  2'b00, 0, 0, 0, 0, 32'hC0C0_C0C0);
    add("rst_rr",      0, 0, 0, 0, 0, 32'h0,          2'b00, 0, 0, 0, 0, 32'h0);
    add("rr_req",      0, 1, 1, 1, 0, 32'h0,          2'b00, 0, 0, 0, 0, 32'h0);
    add("rr_t1",       0, 1, 1, 1, 1, 32'h1111_0001,  2'b01, 1, 0, 1, 0, 32'h1111_0001);
    add("rr_t2_wait",  0, 1, 1, 1, 0, 32'h0,          2'b10, 0, 0, 1, 0, 32'h0);
    add("rr_t2",       0, 1, 1, 1, 1, 32'h2222_0002,  2'b10, 0, 1, 1, 0, 32'h2222_0002);
    add("rr_t3",       0, 1, 1, 1, 1, 32'h3333_0003,  2'b01, 1, 0, 1, 0, 32'h3333_0003);
    add("rr_t4",       0, 1, 0, 1, 1, 32'h4444_0004,  2'b10, 0, 1, 1, 0, 32'h4444_0004);
    add("rr_done",     0, 1, 0, 0, 0, 32'h0,          2'b00, 0, 0, 0, 0, 32'h0);
    add("mid_req",     0, 1, 1, 0, 0, 32'h0,          2'b00, 0, 0, 0, 0, 32'h0);
    add("mid_gnt",     0, 1, 1, 0, 0, 32'h0,          2'b01, 0, 0, 1, 0, 32'h0);
    add("mid_rst",     0, 0, 1, 0, 1, 32'hEEEE_EEEE,  2'b01, 0, 0, 0, 0, 32'hEEEE_EEEE);
    add("mid_after",   0, 1, 0, 0, 0, 32'h0,          2'b00, 0, 0, 0, 0, 32'h0);
    add("fx_rst_idle", 1, 1, 0, 0, 0, 32'h0,          2'b00, 0, 0, 0, 0, 32'h0);
    add("fx_req",      1, 1, 1, 1, 0, 32'h0,          2'b00, 0, 0, 0, 0, 32'h0);
    add("fx_g0a",      1, 1, 1, 1, 1, 32'h0A0A_0A0A,  2'b01, 1, 0, 1, 0, 32'h0A0A_0A0A);
    add("fx_g0b",      1, 1, 1, 1, 1, 32'h0B0B_0B0B,  2'b01, 1, 0, 1, 0, 32'h0B0B_0B0B);
    add("fx_g0c",      1, 1, 1, 1, 1, 32'h0C0C_0C0C,  2'b01, 1, 0, 1, 0, 32'h0C0C_0C0C);
    add("fx_g0_drop",  1, 1, 0, 1, 1, 32'h0D0D_0D0D,  2'b01, 1, 0, 0, 0, 32'h0D0D_0D0D);
    add("fx_g1",       1, 1, 0, 1, 0, 32'h0,          2'b10, 0, 0, 1, 0, 32'h0);
    add("fx_g1_ack",   1, 1, 0, 1, 1, 32'h1E1E_1E1E,  2'b10, 0, 1, 1, 0, 32'h1E1E_1E1E);
    add("fx_g1_again", 1, 1, 0, 0, 0, 32'h0,          2'b10, 0, 0, 0, 0, 32'h0);
    add("fx_idle",     1, 1, 0, 0, 0, 32'h0,          2'b00, 0, 0, 0, 0, 32'h0);
`ifdef SERVANT_ARB_TIMEOUT_EN
    add("to_rst",      0, 0, 0, 0, 0, 32'h0,          2'b00, 0, 0, 0, 0, 32'h0);
    add("to_req",      0, 1, 1, 0, 0, 32'h0,          2'b00, 0, 0, 0, 0, 32'h0);
    for (int k = 1; k <= 14; k++)
      add($sformatf("to_wait%0d", k), 0, 1, 1, 0, 0, 32'h1234_5678,
          2'b01, 0, 0, 1, 0, 32'h1234_5678);
    add("to_fire",     0, 1, 1, 0, 0, 32'h1234_5678,  2'b01, 1, 0, 1, 0, 32'hFFFF_FFFF);
    add("to_idle",     0, 1, 0, 1, 0, 32'h0,          2'b00, 0, 0, 0, 1, 32'h0);
    add("to_g1",       0, 1, 0, 0, 0, 32'h0,          2'b10, 0, 0, 0, 1, 32'h0);
    add("to_end",      0, 1, 0, 0, 0, 32'h0,          2'b00, 0, 0, 0, 1, 32'h0);
`endif

    // Release reset on the fixed-priority instance before its rows begin.
    rst_n[1] = 1'b1;
    foreach (vecs[n]) run_row(vecs[n]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/servant_arbiter.md
Name: servant_arbiter

Overview:
- Two-master, one-slave Wishbone arbiter placed in front of the shared servant data-bus slave (servant_mux/RAM).
- Master 0 is the serv CPU dbus; master 1 is an auxiliary requester, such as a UART boot loader or debug port.
- Grants whole single-beat transactions using round-robin or fixed priority. The grant holds until the slave acks or the master drops cyc.
- Follows the servant bus convention: cyc acts as strobe, ack is a single-cycle pulse, there is no stall, and one beat is outstanding at a time.

Parameters:
- ROUND_ROBIN, 1, 1 = alternate priority after each completed grant; 0 = master 0 always wins ties.
- TIMEOUT_W, 8, width of the watchdog counter; timeout fires after 2**TIMEOUT_W-1 cycles. Used only with the optional feature.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  synchronous reset, active-low
- i_wb_m0_adr  in  32  master 0 address
- i_wb_m0_dat  in  32  master 0 write data
- i_wb_m0_sel  in  4  master 0 byte enables
- i_wb_m0_we  in  1  master 0 write enable
- i_wb_m0_cyc  in  1  master 0 request
- o_wb_m0_rdt  out  32  master 0 read data
- o_wb_m0_ack  out  1  master 0 ack
- i_wb_m1_adr / i_wb_m1_dat / i_wb_m1_sel / i_wb_m1_we / i_wb_m1_cyc  in  32/32/4/1/1  master 1 request, same meanings as master 0
- o_wb_m1_rdt / o_wb_m1_ack  out  32/1  master 1 response
- o_wb_s_adr / o_wb_s_dat / o_wb_s_sel / o_wb_s_we / o_wb_s_cyc  out  32/32/4/1/1  slave request
- i_wb_s_rdt  in  32  slave read data
- i_wb_s_ack  in  1  slave ack
- o_grant  out  2  one-hot current owner; 00 = idle
- o_err  out  1  sticky timeout flag; tied 0 without the optional feature

Behaviour:
- All state is registered on i_clk. While i_rst_n=0 for a cycle:
  - state=IDLE, pointer=0, o_grant=00, o_err=0.
  - o_wb_s_cyc=0 and both master acks=0.
- FSM states:
  - IDLE: no owner.
  - GNT0: master 0 owns the slave.
  - GNT1: master 1 owns the slave.
- IDLE transitions:
  - If exactly one cyc is high, go to the matching GNT state next cycle.
  - If both cyc are high:
    - ROUND_ROBIN=1: the winner is the master not granted last. The pointer resets so that master 0 wins first.
    - ROUND_ROBIN=0: master 0 wins.
  - Grant latency is 1 cycle: request seen in IDLE, slave cyc asserted the next cycle.
- GNTx outputs:
  - o_wb_s_cyc = i_wb_mx_cyc.
  - adr/dat/sel/we are combinationally muxed from master x.
  - In IDLE the slave request outputs mux master 0 with o_wb_s_cyc=0.
- Responses:
  - i_wb_s_rdt goes to both o_wb_mX_rdt unconditionally.
  - o_wb_mx_ack = i_wb_s_ack & (state==GNTx), combinational, zero added latency.
  - The non-owner never sees ack.
- GNTx exit:
  - On i_wb_s_ack: record x as last-granted. If the other master's cyc is high, go directly to GNT(other); otherwise go to IDLE. The same master re-requesting is never chained back-to-back when the other is waiting (RR mode).
  - In fixed-priority mode after the ack: if m0 is requesting, go to GNT0; else if m1 is requesting, go to GNT1; else go to IDLE.
  - If i_wb_mx_cyc drops without ack (abort), go to IDLE next cycle with no ack. The pointer is not updated.
- Ack in IDLE: a spurious i_wb_s_ack is ignored and no master ack is produced.
- Reset mid-transaction: the FSM goes to IDLE. The slave cycle is dropped; a slave ack landing in the reset cycle is discarded.
- o_grant reflects the state register, so it is 00 in IDLE.

Optional Feature:
- Macro: SERVANT_ARB_TIMEOUT_EN.
- When defined:
  - A TIMEOUT_W-bit counter clears on entry to GNTx and increments each GNTx cycle without ack.
  - On reaching all-ones, the arbiter itself pulses o_wb_mx_ack for 1 cycle with o_wb_mx_rdt=32'hFFFF_FFFF (overriding slave rdt that cycle).
  - It then sets o_err=1 (sticky until reset) and exits GNTx as on a normal ack.
- When undefined: no counter, o_err tied 0, and a GNT state waits indefinitely.

Decomposition:
- Package servant_arb_pkg holds:
  - the state enum (IDLE, GNT0, GNT1)
  - localparam TIMEOUT_RDT = 32'hFFFF_FFFF
  - the grant encoding constants
- Natural sub-module: servant_arb_rr, the 2-input round-robin/fixed-priority pick with its pointer register. Its inputs are req[1:0], the advance strobe and the mode; its output is win.
- Muxing and the FSM stay in the top.

Test Plan:
- Single master 0 read:
  - Stimulus: m0 cyc=1, adr=0x100; slave acks 1 cycle after its cyc with rdt=0xDEADBEEF.
  - Required: o_grant=01 at cycle 1; m0 ack at cycle 2 with rdt=0xDEADBEEF; m1 ack stays 0; return to IDLE.
- Simultaneous requests, RR=1:
  - Stimulus: both cyc held for 4 transactions.
  - Required: grant order m0, m1, m0, m1; back-to-back grants with no IDLE cycle between them.
- Simultaneous requests, RR=0:
  - Stimulus: m0 continuously re-requests.
  - Required: m1 never granted while m0 requests; m1 granted in the cycle after m0 drops cyc.
- Abort:
  - Stimulus: m1 granted, then drops cyc before ack.
  - Required: next cycle IDLE, no ack to either master, pointer unchanged (next tie goes to m1 again under RR).
- Reset mid-op:
  - Stimulus: i_rst_n=0 during GNT0 while the slave acks in that same cycle.
  - Required: m0 ack=0, o_grant=00, o_wb_s_cyc=0 the next cycle.
- Timeout (macro defined, TIMEOUT_W=4):
  - Stimulus: slave never acks.
  - Required: at the 15th GNT cycle, m0 ack=1 with rdt=0xFFFFFFFF; o_err=1 and stays 1; FSM returns to IDLE.
